iot_byte_tx: RTL
================

Name: iot_byte_tx

Overview:
Source-side serializer for the IoT data-filter byte stream. It accepts 128-bit sample words from an upstream producer over a valid/ready handshake and emits each word as 16 bytes, MSB byte first, on iot_in/in_en. It honours the consumer's busy back-pressure and drives a fixed fn_sel for the whole run. One run is a fixed number of words; it is used as the stimulus/driver end of the filter datapath.

Parameters:
DATA_W, 128, word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, byte width on iot_in
WORDS_PER_RUN, 96, words per run (12 rounds x 8)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a run when IDLE
fn_sel_in  input  3  function code, captured at start
word_valid  input  1  upstream word available
word_data  input  DATA_W  upstream word
word_ready  output  1  block accepts word this cycle
busy  input  1  consumer pause request
in_en  output  1  iot_in carries a valid byte this cycle
iot_in  output  BYTE_W  byte to consumer
fn_sel  output  3  function code for the run
word_cnt  output  7  words fully sent in current run
run_done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst_n=0, async): state=IDLE; in_en=0, iot_in=0, fn_sel=0, word_cnt=0, run_done=0; shift register and byte counter cleared. Reset mid-run discards any partial word; there is no resumption.
- All outputs except word_ready are registered. word_ready = (state==LOAD), combinational from state only.
- IDLE: start=1 at an edge -> fn_sel<=fn_sel_in, word_cnt<=0, state<=LOAD. start is ignored in every other state.
- LOAD: word_ready=1. On an edge with word_valid=1: shreg<=word_data, byte_cnt<=0, state<=SEND. in_en<=0 during LOAD.
- SEND: at each edge, busy=0 -> iot_in<=shreg[DATA_W-1 -: BYTE_W], in_en<=1, shreg<<=BYTE_W, byte_cnt++. busy=1 -> in_en<=0; shreg and byte_cnt hold; iot_in holds its last value.
- A byte is transferred in every cycle where in_en=1. No byte is lost or repeated across busy stalls of any length.
- Last byte: when the byte issued is byte 15 (byte_cnt==15 with busy=0), word_cnt++ on the same edge. If the new word_cnt==WORDS_PER_RUN, state<=DONE; otherwise state<=LOAD.
- Throughput: at least 17 cycles per word (16 bytes + 1 LOAD cycle), more with busy stalls or word_valid gaps.
- Latency: word accepted at edge E -> first byte (word_data[127:120]) shows in_en=1 after edge E+1 if busy=0 at E+1.
- DONE: one cycle; run_done<=1 for exactly one cycle, in_en<=0, state<=IDLE. fn_sel and word_cnt hold until the next start.
- word_cnt saturates at WORDS_PER_RUN and never wraps within a run.
- busy is ignored outside SEND.

Optional Feature:
Macro IOT_TX_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits, reset 0). It clears at start and increments each cycle in SEND where busy=1, saturating at 16'hFFFF.
- Undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Single word: WORDS_PER_RUN=1, start, fn_sel_in=3'b011, word_data=128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, busy=0 -> in_en high 16 consecutive cycles carrying 00,11,...,FF; fn_sel=3; word_cnt=1; run_done pulses once.
- Back-pressure: busy=1 for 5 cycles after the 4th byte -> in_en=0 for those 5 cycles; the byte sequence is unchanged; 16 in_en cycles total. With the macro defined, stall_cnt=5.
- Full run: 96 words with word_valid always 1, busy=0 -> 1536 bytes; word_cnt reaches 96; run_done pulses; return to IDLE at cycle 96*17+2 after start.
- Upstream gaps: word_valid low 10 cycles between words -> word_ready stays high through the gap; no in_en during the gap; next word is correct.
- Reset mid-word: rst_n=0 after 7 bytes -> outputs go to 0 immediately; after release, start+new word -> a clean 16-byte word with no residue.
- Start ignored while running: start pulsed with fn_sel_in=7 during SEND -> fn_sel and word_cnt unaffected.

Source files
------------

// File: rtl/iot_byte_tx_if.sv
// Upstream word handshake and consumer byte lane of the IoT byte serializer.
// The master side is the producer/consumer environment; the slave side is iot_byte_tx.
interface iot_byte_tx_if #(
    parameter int DATA_W = 128,
    parameter int BYTE_W = 8
);
    logic              word_valid;
    logic [DATA_W-1:0] word_data;
    logic              word_ready;
    logic              busy;
    logic              in_en;
    logic [BYTE_W-1:0] iot_in;

    modport master (
        output word_valid, word_data, busy,
        input  word_ready, in_en, iot_in
    );

    modport slave (
        input  word_valid, word_data, busy,
        output word_ready, in_en, iot_in
    );
endinterface

// File: rtl/iot_byte_tx.sv
// Serializes DATA_W-bit words into BYTE_W-bit bytes, MSB byte first, for a fixed-length run.
// Optional macro IOT_TX_STALL_CNT_EN adds o_stall_cnt, counting busy stall cycles in SEND.
module iot_byte_tx #(
    parameter int DATA_W        = 128,
    parameter int BYTE_W        = 8,
    parameter int WORDS_PER_RUN = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [2:0]   i_fn_sel_in,
    iot_byte_tx_if.slave bus,
    output logic [2:0]   o_fn_sel,
    output logic [6:0]   o_word_cnt,
    output logic         o_run_done
`ifdef IOT_TX_STALL_CNT_EN
    ,
    output logic [15:0]  o_stall_cnt
`endif
);

    localparam int              NBYTES    = DATA_W / BYTE_W;
    localparam int              BC_W      = $clog2(NBYTES);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);
    localparam logic [6:0]      WPR       = 7'(WORDS_PER_RUN);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shreg;
    logic [BC_W-1:0]   r_byte_cnt;
    logic              r_in_en;
    logic [BYTE_W-1:0] r_iot_in;
    logic [2:0]        r_fn_sel;
    logic [6:0]        r_word_cnt;
    logic              r_run_done;
    logic              w_word_ready;
    logic              w_last_byte;

    // Final byte of a word leaves on this edge; busy holds it back.
    assign w_last_byte = (r_state == SEND) && !bus.busy && (r_byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = LOAD;
            LOAD:    if (bus.word_valid) w_next = SEND;
            SEND:    if (w_last_byte) w_next = ((r_word_cnt + 7'd1) >= WPR) ? DONE : LOAD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_word_ready = (r_state == LOAD);
    end

`ifdef IOT_TX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_stall_cnt <= '0;
        end else if (r_state == SEND && bus.busy) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_byte_cnt <= '0;
            r_in_en    <= 1'b0;
            r_iot_in   <= '0;
            r_fn_sel   <= '0;
            r_word_cnt <= '0;
            r_run_done <= 1'b0;
        end else begin
            r_in_en    <= 1'b0;
            r_run_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_fn_sel   <= i_fn_sel_in;
                        r_word_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (bus.word_valid) begin
                        r_shreg    <= bus.word_data;
                        r_byte_cnt <= '0;
                    end
                end
                SEND: begin
                    // iot_in keeps its last byte through a stall so nothing is repeated or lost.
                    if (!bus.busy) begin
                        r_iot_in   <= r_shreg[DATA_W-1 -: BYTE_W];
                        r_in_en    <= 1'b1;
                        r_shreg    <= r_shreg << BYTE_W;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (w_last_byte && r_word_cnt != WPR) begin
                            r_word_cnt <= r_word_cnt + 7'd1;
                        end
                    end
                end
                DONE: begin
                    r_run_done <= 1'b1;
                end
                default: begin
                    r_run_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_ready = w_word_ready;
    assign bus.in_en      = r_in_en;
    assign bus.iot_in     = r_iot_in;
    assign o_fn_sel       = r_fn_sel;
    assign o_word_cnt     = r_word_cnt;
    assign o_run_done     = r_run_done;

endmodule
